lif_mux_array: RTL and testbench



---
 rtl/lif_mux_array.sv | 91 +++++++++
 tb/tb_lif_mux_array.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lif_mux_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: one shared update
// datapath walks a channel register file in round-robin order, one channel per enabled cycle.
//
// state      | meaning
// CH0..CHN-1 | ptr value; channel updated on the next enabled edge, wraps N_CH-1 -> 0
module lif_mux_array #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  localparam int PW        = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH*WIDTH-1:0] current_in,
  output logic [N_CH-1:0]       spike,
  output logic [WIDTH-1:0]      state_out,
  output logic [PW-1:0]         ch_out,
  output logic                  frame_done
);

  localparam logic [WIDTH-1:0] TH      = WIDTH'(THRESHOLD);
  localparam logic [3:0]       RF      = 4'(REFRACT);
  localparam logic [PW-1:0]    LAST_CH = PW'(N_CH - 1);

  logic [WIDTH-1:0] state_q [N_CH];
  logic [3:0]       rcnt_q  [N_CH];
  logic [PW-1:0]    ptr;

  logic [WIDTH-1:0] cur_state;
  logic [WIDTH-1:0] cur_i;
  logic [3:0]       cur_rcnt;
  logic [WIDTH-1:0] leak;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;
  logic             refr;
  logic             fire;
  logic [WIDTH-1:0] next_state;
  logic [3:0]       next_rcnt;
  logic [PW-1:0]    next_ptr;

  always_comb begin
    cur_state  = state_q[ptr];
    cur_rcnt   = rcnt_q[ptr];
    cur_i      = current_in[int'(ptr)*WIDTH +: WIDTH];
    leak       = cur_state - (cur_state >> LEAK_SHIFT);
    sum        = {1'b0, leak} + {1'b0, cur_i};
    // Saturate before the threshold compare so a wrapped sum can never dodge a spike.
    sat        = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    refr       = (cur_rcnt != 4'd0);
    fire       = !refr && (sat >= TH);
    next_state = sat;
    next_rcnt  = 4'd0;
    if (refr) begin
      next_state = leak;
      next_rcnt  = cur_rcnt - 4'd1;
    end else if (fire) begin
      next_state = sat - TH;
      next_rcnt  = RF;
    end
    next_ptr = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= '0;
        rcnt_q[i]  <= '0;
      end
      ptr        <= '0;
      spike      <= '0;
      state_out  <= '0;
      ch_out     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        state_q[ptr] <= next_state;
        rcnt_q[ptr]  <= next_rcnt;
        spike[ptr]   <= fire;
        state_out    <= next_state;
        ch_out       <= ptr;
        frame_done   <= (ptr == LAST_CH);
        ptr          <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_lif_mux_array.sv
// Directed bench for lif_mux_array with the default parameter set
// (N_CH=4, WIDTH=8, THRESHOLD=200, LEAK_SHIFT=1, REFRACT=2).
module tb_lif_mux_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] current_in;
  logic [3:0]  spike;
  logic [7:0]  state_out;
  logic [1:0]  ch_out;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_mux_array #(
    .N_CH(4), .WIDTH(8), .THRESHOLD(200), .LEAK_SHIFT(1), .REFRACT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .current_in(current_in),
    .spike(spike),
    .state_out(state_out),
    .ch_out(ch_out),
    .frame_done(frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    en         = 1'b1;
    current_in = 32'hA5_FF_37_C8;
    repeat (3) tick();
    total++;
    if ({spike, state_out, ch_out, frame_done} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got spike=%b state=%0d ch=%0d fd=%b want all 0",
               spike, state_out, ch_out, frame_done);
    end
    rst        = 1'b0;
    current_in = 32'd0;
    tick();
    total++;
    if (ch_out !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_ch got=%0d want=0", ch_out);
    end
  endtask

  task automatic check_ch0_run(input string tag, input int visits);
    logic [7:0] exp_s  [6] = '{8'd128, 8'd192, 8'd24, 8'd12, 8'd6, 8'd131};
    logic       exp_sp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < visits; v++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        total++;
        if (ch_out !== 2'(c)) begin
          bad++;
          $display("FAIL %s_ch v=%0d got=%0d want=%0d", tag, v, ch_out, c);
        end
        total++;
        if (c == 0) begin
          if (state_out !== exp_s[v] || spike[0] !== exp_sp[v]) begin
            bad++;
            $display("FAIL %s_ch0 v=%0d got state=%0d spike0=%b want state=%0d spike0=%b",
                     tag, v, state_out, spike[0], exp_s[v], exp_sp[v]);
          end
        end else begin
          if (state_out !== 8'd0 || spike[c] !== 1'b0) begin
            bad++;
            $display("FAIL %s_other v=%0d ch=%0d got state=%0d spike=%b want 0",
                     tag, v, c, state_out, spike[c]);
          end
        end
      end
    end
  endtask

  task automatic test_integrate();
    do_reset();
    current_in = {8'd0, 8'd0, 8'd0, 8'd128};
    check_ch0_run("integ", 6);
  endtask

  task automatic test_saturation();
    logic [7:0] exp_s  [4] = '{8'd55, 8'd28, 8'd14, 8'd55};
    logic       exp_sp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    current_in = {8'd0, 8'd0, 8'd255, 8'd0};
    for (int v = 0; v < 4; v++) begin
      tick();
      tick();
      total++;
      if (ch_out !== 2'd1 || state_out !== exp_s[v] || spike[1] !== exp_sp[v]) begin
        bad++;
        $display("FAIL sat_ch1 v=%0d got ch=%0d state=%0d spike1=%b want ch=1 state=%0d spike1=%b",
                 v, ch_out, state_out, spike[1], exp_s[v], exp_sp[v]);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    current_in = 32'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (ch_out !== 2'(i % 4) || frame_done !== ((i % 4) == 3)) begin
        bad++;
        $display("FAIL wrap i=%0d got ch=%0d fd=%b want ch=%0d fd=%b",
                 i, ch_out, frame_done, i % 4, (i % 4) == 3);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    current_in = {8'd0, 8'd50, 8'd100, 8'd255};
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (ch_out !== 2'd1 || state_out !== 8'd100 || spike !== 4'b0001 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL en_hold i=%0d got ch=%0d state=%0d spike=%b fd=%b want ch=1 state=100 spike=0001 fd=0",
                 i, ch_out, state_out, spike, frame_done);
      end
    end
    en = 1'b1;
    tick();
    total++;
    if (ch_out !== 2'd2 || state_out !== 8'd50 || spike !== 4'b0001) begin
      bad++;
      $display("FAIL en_resume got ch=%0d state=%0d spike=%b want ch=2 state=50 spike=0001",
               ch_out, state_out, spike);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    current_in = {8'd0, 8'd0, 8'd0, 8'd128};
    repeat (8) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({spike, state_out, ch_out, frame_done} !== 15'd0) begin
      bad++;
      $display("FAIL midrst_clear got spike=%b state=%0d ch=%0d fd=%b want all 0",
               spike, state_out, ch_out, frame_done);
    end
    rst = 1'b0;
    check_ch0_run("midrst", 3);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    current_in = 32'd0;
    test_reset();
    test_integrate();
    test_saturation();
    test_wrap();
    test_enable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
